// File: rtl/parity_frame_ctrl.sv
// Serial parity frame receiver: five data bits MSB-first followed by one parity bit.
// The result is held until the consumer acknowledges it. A frame is aborted if the
// gap between two bits grows too long.
module parity_frame_ctrl #(
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       out_valid,
  output logic [4:0] word,
  output logic       par_err,
  output logic       timeout,
  output logic [3:0] err_count
);

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e     state_q, state_d;
  logic [4:0] word_q, word_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       par_acc_q, par_acc_d;
  logic       par_err_q, par_err_d;
  logic       busy_q, busy_d;
  logic       out_valid_q, out_valid_d;
  logic       timeout_q, timeout_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic       parity_bad;

  // Mismatch between the completed six-bit XOR and the selected parity sense.
  always_comb begin
    parity_bad = (par_acc_q ^ bit_in) != PARITY_ODD;
  end

  // Next-state logic; busy and out_valid are derived from the next state so that
  // they come straight out of flops.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    par_acc_d  = par_acc_q;
    par_err_d  = par_err_q;
    err_cnt_d  = err_cnt_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // bit_valid is deliberately ignored here, even alongside start.
        if (start) begin
          state_d    = StRecv;
          word_d     = '0;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
          par_acc_d  = 1'b0;
        end
      end
      StRecv: begin
        if (start) begin
          // Restart: drop the partial frame and this cycle's bit.
          word_d     = '0;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
          par_acc_d  = 1'b0;
        end else if (bit_valid) begin
          idle_cnt_d = '0;
          if (bit_cnt_q == 3'd5) begin
            state_d   = StDone;
            par_err_d = parity_bad;
            if (parity_bad && (err_cnt_q != 4'hf)) begin
              err_cnt_d = err_cnt_q + 4'd1;
            end
          end else begin
            word_d    = {word_q[3:0], bit_in};
            par_acc_d = par_acc_q ^ bit_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (idle_cnt_q + 8'd1 == TimeoutLim) begin
          state_d    = StIdle;
          timeout_d  = 1'b1;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d   = StIdle;
          par_err_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d      = (state_d == StRecv);
    out_valid_d = (state_d == StDone);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      word_q      <= '0;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      par_acc_q   <= 1'b0;
      par_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      par_acc_q   <= par_acc_d;
      par_err_q   <= par_err_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign word      = word_q;
  assign par_err   = par_err_q;
  assign timeout   = timeout_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: two instances (even parity / short timeout, and odd parity /
// default timeout) share one stimulus stream and are compared every cycle with a frame-level
// reference model.
module tb_parity_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       busy_a, ov_a, pe_a, to_a;
  logic [4:0] word_a;
  logic [3:0] ec_a;
  logic       busy_b, ov_b, pe_b, to_b;
  logic [4:0] word_b;
  logic [3:0] ec_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parity_frame_ctrl #(.PARITY_ODD(1'b0), .TIMEOUT(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .out_ready (out_ready),
    .busy      (busy_a),
    .out_valid (ov_a),
    .word      (word_a),
    .par_err   (pe_a),
    .timeout   (to_a),
    .err_count (ec_a)
  );

  parity_frame_ctrl #(.PARITY_ODD(1'b1), .TIMEOUT(15)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .out_ready (out_ready),
    .busy      (busy_b),
    .out_valid (ov_b),
    .word      (word_b),
    .par_err   (pe_b),
    .timeout   (to_b),
    .err_count (ec_b)
  );

  // Reference model: a frame is a count of bits plus their value; parity from a popcount.
  typedef struct {
    bit in_frame;
    bit holding;
    int nbits;
    int val;
    int idle;
    int hold_word;
    bit hold_err;
    bit tpulse;
    int errs;
  } mdl_t;

  mdl_t m [2];
  int   odd_p [2] = '{0, 1};
  int   tmo_p [2] = '{4, 15};

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.in_frame = 0; z.holding = 0; z.nbits = 0; z.val = 0; z.idle = 0;
    z.hold_word = 0; z.hold_err = 0; z.tpulse = 0; z.errs = 0;
    return z;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input bit st, input bit b, input bit bv,
                                    input bit rdy, input int odd, input int tmo);
    int ones;
    s.tpulse = 0;
    if (s.holding) begin
      if (rdy) s.holding = 0;
    end else if (s.in_frame) begin
      if (st) begin
        s.nbits = 0; s.val = 0; s.idle = 0;
      end else if (bv) begin
        s.idle = 0;
        if (s.nbits < 5) begin
          s.val = s.val * 2 + int'(b);
          s.nbits++;
        end else begin
          ones = $countones(s.val) + int'(b);
          s.hold_err = ((ones % 2) != odd);
          s.hold_word = s.val;
          s.holding = 1;
          s.in_frame = 0;
          if (s.hold_err && s.errs < 15) s.errs++;
        end
      end else begin
        s.idle++;
        if (s.idle >= tmo) begin
          s.in_frame = 0;
          s.tpulse = 1;
        end
      end
    end else if (st) begin
      s.in_frame = 1; s.nbits = 0; s.val = 0; s.idle = 0;
    end
    return s;
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string n, input int k, input logic bsy, input logic ov,
                           input logic [4:0] w, input logic pe, input logic tp,
                           input logic [3:0] ec);
    check_eq({n, "_busy"}, int'(bsy), int'(m[k].in_frame));
    check_eq({n, "_out_valid"}, int'(ov), int'(m[k].holding));
    check_eq({n, "_timeout"}, int'(tp), int'(m[k].tpulse));
    check_eq({n, "_err_count"}, int'(ec), m[k].errs);
    if (m[k].holding) begin
      check_eq({n, "_word"}, int'(w), m[k].hold_word);
      check_eq({n, "_par_err"}, int'(pe), int'(m[k].hold_err));
    end
  endtask

  // One clock with the given inputs; called and returns on a falling edge.
  task automatic cycle(input bit st, input bit b, input bit bv, input bit rdy);
    start = st; bit_in = b; bit_valid = bv; out_ready = rdy;
    @(posedge clk);
    for (int k = 0; k < 2; k++) m[k] = mdl_step(m[k], st, b, bv, rdy, odd_p[k], tmo_p[k]);
    @(negedge clk);
    check_dut("a", 0, busy_a, ov_a, word_a, pe_a, to_a, ec_a);
    check_dut("b", 1, busy_b, ov_b, word_b, pe_b, to_b, ec_b);
  endtask

  // Start (with a stray bit_valid that must be ignored) then six bits, f[5] first.
  task automatic send_frame(input logic [5:0] f);
    cycle(1, 1, 1, 0);
    for (int i = 5; i >= 0; i--) cycle(0, f[i], 1, 0);
  endtask

  // Asynchronous reset while the clock is low; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_busy"}, int'(busy_a | busy_b), 0);
    check_eq({tag, "_out_valid"}, int'(ov_a | ov_b), 0);
    check_eq({tag, "_word"}, int'(word_a | word_b), 0);
    check_eq({tag, "_par_err"}, int'(pe_a | pe_b), 0);
    check_eq({tag, "_timeout"}, int'(to_a | to_b), 0);
    check_eq({tag, "_err_count"}, int'(ec_a | ec_b), 0);
    m[0] = mdl_zero();
    m[1] = mdl_zero();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m[0] = mdl_zero();
    m[1] = mdl_zero();
    @(negedge clk);
    check_eq("por_busy", int'(busy_a), 0);
    check_eq("por_out_valid", int'(ov_a), 0);
    check_eq("por_word", int'(word_a), 0);
    check_eq("por_err_count", int'(ec_a), 0);
    rst_n = 1'b1;

    // Even parity, good frame.
    send_frame(6'b100111);
    check_eq("even_word", int'(word_a), 5'b10011);
    check_eq("even_par_err", int'(pe_a), 0);
    check_eq("even_valid", int'(ov_a), 1);
    check_eq("even_err_count", int'(ec_a), 0);
    cycle(0, 0, 0, 1);

    // Parity error, held for five cycles without out_ready.
    send_frame(6'b111110);
    check_eq("perr_word", int'(word_a), 5'b11111);
    check_eq("perr_par_err", int'(pe_a), 1);
    check_eq("perr_err_count", int'(ec_a), 1);
    repeat (5) cycle(0, 1, 1, 0);
    check_eq("hold_word", int'(word_a), 5'b11111);
    check_eq("hold_valid", int'(ov_a), 1);
    cycle(1, 0, 0, 1);
    check_eq("ack_valid", int'(ov_a), 0);

    // Timeout after four idle cycles (instance a).
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);
    check_eq("pre_timeout", int'(to_a), 0);
    cycle(0, 0, 0, 0);
    check_eq("timeout_pulse", int'(to_a), 1);
    check_eq("timeout_busy", int'(busy_a), 0);
    check_eq("timeout_valid", int'(ov_a), 0);
    cycle(0, 0, 0, 0);
    check_eq("timeout_once", int'(to_a), 0);

    // A bit on the would-be timeout cycle keeps the frame alive.
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 0);
    check_eq("late_bit_busy", int'(busy_a), 1);
    check_eq("late_bit_no_to", int'(to_a), 0);

    // Restart mid-frame.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0);
    send_frame(6'b001001);
    check_eq("restart_word", int'(word_a), 5'b00100);
    check_eq("restart_par_err", int'(pe_a), 0);
    cycle(0, 0, 0, 1);

    // Odd parity instance.
    send_frame(6'b000001);
    check_eq("odd_good", int'(pe_b), 0);
    cycle(0, 0, 0, 1);
    send_frame(6'b000000);
    check_eq("odd_bad", int'(pe_b), 1);
    cycle(0, 0, 0, 1);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      cycle(bit'($urandom_range(0, 29) == 0), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 9) < 6), bit'($urandom_range(0, 3) == 0));
    end

    // Saturation of the error counter.
    do_reset("rst_rand");
    for (int i = 1; i <= 17; i++) begin
      send_frame(6'b111110);
      if (i == 15) check_eq("sat_at_15", int'(ec_a), 15);
      cycle(0, 0, 0, 1);
    end
    check_eq("sat_hold", int'(ec_a), 15);

    // Reset mid-frame, then start on the first edge after release.
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    do_reset("rst_mid");
    cycle(1, 0, 0, 0);
    check_eq("post_rst_start", int'(busy_a), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
